// File: rtl/prime_search_ctrl.sv
// Prime-search sequencer: draws LFSR candidates and drives an external miller_rabin core until a prime is found or the budget runs out.
// Optional macro PRIME_SEARCH_STATS_EN exposes the live attempt counter on the `attempts` port.
module prime_search_ctrl #(
    parameter int unsigned WORD_WIDTH    = 32,
    parameter int unsigned ATTEMPT_WIDTH = 8,
    parameter int unsigned MAX_ATTEMPTS  = 255,
    parameter logic [WORD_WIDTH-1:0] LFSR_TAPS = WORD_WIDTH'(32'h80200003)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     seed_load,
    input  logic [WORD_WIDTH-1:0]    seed,
    input  logic [5:0]               security_parameter,
    output logic                     busy,
    output logic                     done,
    output logic                     success,
    output logic [WORD_WIDTH-1:0]    prime,
    output logic                     mr_rst,
    output logic                     mr_enable,
    output logic [WORD_WIDTH-1:0]    mr_n,
    output logic [5:0]               mr_security_parameter,
    input  logic                     mr_done,
    input  logic                     mr_is_prime
`ifdef PRIME_SEARCH_STATS_EN
    ,
    output logic [ATTEMPT_WIDTH-1:0] attempts
`endif
);

    typedef enum logic [2:0] {IDLE, DRAW, LAUNCH, WAIT, FIN} state_t;

    // Candidates are forced odd with the top bit set
    localparam logic [WORD_WIDTH-1:0] CAND_MASK =
        {1'b1, {(WORD_WIDTH-2){1'b0}}, 1'b1};
    localparam logic [ATTEMPT_WIDTH-1:0] MAX_CNT = ATTEMPT_WIDTH'(MAX_ATTEMPTS);

    state_t                   state, state_nx;
    logic [WORD_WIDTH-1:0]    lfsr, lfsr_nx, lfsr_step;
    logic [ATTEMPT_WIDTH-1:0] attempt_cnt, attempt_nx;
    logic [WORD_WIDTH-1:0]    mr_n_nx, prime_nx;
    logic [5:0]               sp_nx;
    logic                     success_nx;
    logic                     busy_nx, done_nx, mr_rst_nx, mr_enable_nx;

    assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);

`ifdef PRIME_SEARCH_STATS_EN
    assign attempts = attempt_cnt;
`endif

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                 <= IDLE;
            lfsr                  <= WORD_WIDTH'(1);
            attempt_cnt           <= '0;
            mr_n                  <= '0;
            prime                 <= '0;
            mr_security_parameter <= '0;
            success               <= 1'b0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            mr_rst                <= 1'b0;
            mr_enable             <= 1'b0;
        end else begin
            state                 <= state_nx;
            lfsr                  <= lfsr_nx;
            attempt_cnt           <= attempt_nx;
            mr_n                  <= mr_n_nx;
            prime                 <= prime_nx;
            mr_security_parameter <= sp_nx;
            success               <= success_nx;
            busy                  <= busy_nx;
            done                  <= done_nx;
            mr_rst                <= mr_rst_nx;
            mr_enable             <= mr_enable_nx;
        end
    end

    // Next-state and next-output logic; pulse outputs follow the state being entered
    always_comb begin
        state_nx   = state;
        lfsr_nx    = lfsr;
        attempt_nx = attempt_cnt;
        mr_n_nx    = mr_n;
        prime_nx   = prime;
        sp_nx      = mr_security_parameter;
        success_nx = success;

        case (state)
            IDLE: begin
                if (seed_load) begin
                    lfsr_nx = (seed == '0) ? WORD_WIDTH'(1) : seed;
                end
                if (start) begin
                    sp_nx      = security_parameter;
                    attempt_nx = '0;
                    success_nx = 1'b0;
                    state_nx   = DRAW;
                end
            end
            DRAW: begin
                lfsr_nx    = lfsr_step;
                mr_n_nx    = lfsr_step | CAND_MASK;
                attempt_nx = attempt_cnt + ATTEMPT_WIDTH'(1);
                state_nx   = LAUNCH;
            end
            LAUNCH: begin
                state_nx = WAIT;
            end
            WAIT: begin
                if (mr_done) begin
                    if (mr_is_prime) begin
                        success_nx = 1'b1;
                        prime_nx   = mr_n;
                        state_nx   = FIN;
                    end else if (attempt_cnt == MAX_CNT) begin
                        success_nx = 1'b0;
                        prime_nx   = mr_n;
                        state_nx   = FIN;
                    end else begin
                        state_nx = DRAW;
                    end
                end
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        busy_nx      = (state_nx != IDLE);
        done_nx      = (state_nx == FIN);
        mr_rst_nx    = (state_nx == DRAW);
        mr_enable_nx = (state_nx == LAUNCH);
    end

endmodule

// File: tb/tb_prime_search_ctrl.sv
// Scoreboard bench for prime_search_ctrl with a behavioural miller_rabin core model.
module tb_prime_search_ctrl;

    localparam logic [31:0] TAPS = 32'h80200003;
    localparam logic [31:0] MASK = 32'h80000001;

    typedef struct {
        logic [31:0] n;
        logic [7:0]  att;
    } cand_t;

    typedef struct {
        logic        success;
        logic [31:0] prime;
        logic [7:0]  att;
        logic [5:0]  sp;
    } res_t;

    logic        clk, rst, start, seed_load;
    logic [31:0] seed;
    logic [5:0]  security_parameter;
    logic        busy, done, success, mr_rst, mr_enable;
    logic [31:0] prime, mr_n;
    logic [5:0]  mr_security_parameter;
    logic        mr_done, mr_is_prime;
    logic [7:0]  attempts_obs;

    int total = 0;
    int bad   = 0;

    cand_t cand_q[$];
    res_t  res_q[$];
    logic [31:0] m_lfsr;

    int core_comps = 0;
    int lat        = 5;
    int idx;
    int cnt;
    logic active;

    prime_search_ctrl #(
        .WORD_WIDTH(32), .ATTEMPT_WIDTH(8), .MAX_ATTEMPTS(4), .LFSR_TAPS(TAPS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .seed_load(seed_load), .seed(seed),
        .security_parameter(security_parameter), .busy(busy), .done(done),
        .success(success), .prime(prime), .mr_rst(mr_rst), .mr_enable(mr_enable),
        .mr_n(mr_n), .mr_security_parameter(mr_security_parameter),
        .mr_done(mr_done), .mr_is_prime(mr_is_prime)
`ifdef PRIME_SEARCH_STATS_EN
        , .attempts(attempts_obs)
`endif
    );

`ifndef PRIME_SEARCH_STATS_EN
    assign attempts_obs = dut.attempt_cnt;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : 32'h0);
    endfunction

    // Behavioural core: verdict is composite for the first core_comps tests of a search
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mr_done     <= 1'b0;
            mr_is_prime <= 1'b0;
            active      <= 1'b0;
            cnt         <= 0;
            idx         <= 0;
        end else begin
            if (start && !busy) idx <= 0;
            if (mr_rst) begin
                mr_done     <= 1'b0;
                mr_is_prime <= 1'b0;
                active      <= 1'b0;
            end else if (mr_enable) begin
                active <= 1'b1;
                cnt    <= lat;
            end else if (active) begin
                if (cnt <= 1) begin
                    mr_done     <= 1'b1;
                    mr_is_prime <= (idx >= core_comps);
                    idx         <= idx + 1;
                    active      <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT launches a candidate or completes
    logic        prev_mr_rst, prev_mr_done, in_flight;
    logic [31:0] held_n;
    always @(negedge clk) begin
        cand_t c;
        res_t  r;
        if (rst) begin
            in_flight    = 1'b0;
            prev_mr_rst  = 1'b0;
            prev_mr_done = 1'b0;
        end else begin
            if (mr_enable) begin
                if (cand_q.size() == 0) begin
                    chk("unexpected_launch", 32'(mr_n), 32'hFFFF_FFFF);
                end else begin
                    c = cand_q.pop_front();
                    chk("mr_n", mr_n, c.n);
                    chk("attempts_live", 32'(attempts_obs), 32'(c.att));
                end
                chk("rst_before_enable", 32'(prev_mr_rst), 32'd1);
                chk("odd_msb", 32'({mr_n[31], mr_n[0]}), 32'd3);
                in_flight = 1'b1;
                held_n    = mr_n;
            end else if (in_flight) begin
                chk("mr_n_stable", mr_n, held_n);
                if (mr_done) in_flight = 1'b0;
            end
            if (done) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    r = res_q.pop_front();
                    chk("success", 32'(success), 32'(r.success));
                    chk("prime", prime, r.prime);
                    chk("attempts_done", 32'(attempts_obs), 32'(r.att));
                    chk("mr_sp", 32'(mr_security_parameter), 32'(r.sp));
                    chk("busy_with_done", 32'(busy), 32'd1);
                    chk("mr_done_before_done", 32'(prev_mr_done), 32'd1);
                end
            end
            prev_mr_rst  = mr_rst;
            prev_mr_done = mr_done;
        end
    end

    task automatic push_model(input int n, input bit succ, input logic [5:0] sp);
        res_t r;
        for (int i = 1; i <= n; i++) begin
            m_lfsr = step(m_lfsr);
            cand_q.push_back('{n: m_lfsr | MASK, att: 8'(i)});
        end
        r = '{success: succ, prime: m_lfsr | MASK, att: 8'(n), sp: sp};
        res_q.push_back(r);
    endtask

    task automatic drive_and_wait(input logic [5:0] sp, input bit poke);
        int n;
        security_parameter = sp;
        start = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        seed_load = 1'b0;
        chk("mr_rst_k1", 32'(mr_rst), 32'd1);
        @(posedge clk); #1;
        chk("mr_enable_k2", 32'(mr_enable), 32'd1);
        if (poke) begin
            @(posedge clk); #1;
            start              = 1'b1;
            seed_load          = 1'b1;
            seed               = 32'h12345678;
            security_parameter = 6'h3F;
            @(posedge clk); #1;
            start     = 1'b0;
            seed_load = 1'b0;
        end
        n = 0;
        while (!done && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) begin
            chk("done_timeout", 32'(done), 32'd1);
        end else begin
            @(posedge clk); #1;
            chk("busy_after_done", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; seed_load = 1'b0; seed = '0; security_parameter = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_success", 32'(success), 32'd0);
        chk("rst_prime", prime, 32'd0);
        chk("rst_mr_n", mr_n, 32'd0);
        chk("rst_mr_ctl", 32'({mr_rst, mr_enable}), 32'd0);
        chk("rst_mr_sp", 32'(mr_security_parameter), 32'd0);
        chk("rst_attempts", 32'(attempts_obs), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Seed 0 falls back to lfsr=1: composite, composite, prime
        seed = 32'h0; seed_load = 1'b1;
        @(posedge clk); #1 seed_load = 1'b0;
        m_lfsr = 32'h1;
        cand_q.push_back('{n: 32'h80200003, att: 8'd1});
        cand_q.push_back('{n: 32'hC0300003, att: 8'd2});
        cand_q.push_back('{n: 32'hE0180001, att: 8'd3});
        res_q.push_back('{success: 1'b1, prime: 32'hE0180001, att: 8'd3, sp: 6'd20});
        repeat (3) m_lfsr = step(m_lfsr);
        core_comps = 2;
        drive_and_wait(6'd20, 1'b0);

        // Budget exhausted
        core_comps = 100;
        push_model(4, 1'b0, 6'd7);
        drive_and_wait(6'd7, 1'b0);

        // Seed and start together; start/seed_load pulsed in WAIT are ignored
        seed = 32'hDEADBEEF; seed_load = 1'b1;
        m_lfsr = 32'hDEADBEEF;
        core_comps = 1;
        push_model(2, 1'b1, 6'd33);
        drive_and_wait(6'd33, 1'b1);

        // 1000 draws with a fast core
        lat = 1;
        for (int s = 0; s < 250; s++) begin
            core_comps = 100;
            push_model(4, 1'b0, 6'd12);
            drive_and_wait(6'd12, 1'b0);
        end

        // Reset in WAIT: no done, LFSR back to 1, restart at attempt 1
        lat = 5;
        core_comps = 100;
        m_lfsr = step(m_lfsr);
        cand_q.push_back('{n: m_lfsr | MASK, att: 8'd1});
        security_parameter = 6'd9;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (!mr_enable && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_launch", 32'(mr_enable), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        cand_q.delete();
        res_q.delete();
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_mr_enable", 32'(mr_enable), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_idle", 32'({busy, done}), 32'd0);
        end
        m_lfsr = 32'h1;
        core_comps = 0;
        cand_q.push_back('{n: 32'h80200003, att: 8'd1});
        res_q.push_back('{success: 1'b1, prime: 32'h80200003, att: 8'd1, sp: 6'd9});
        m_lfsr = step(m_lfsr);
        @(posedge clk); #1;
        drive_and_wait(6'd9, 1'b0);

        repeat (3) @(posedge clk);
        chk("cand_q_empty", 32'(cand_q.size()), 32'd0);
        chk("res_q_empty", 32'(res_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
